// File: rtl/dmem_access_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage data-memory access controller. It checks load/store alignment and
// issues one word-aligned bus transaction with byte enables and lane-replicated
// store data. The pipeline is stalled until the bus acknowledges. The raw read
// word, its byte address and its size code are then handed downstream.
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a bus transaction that has
// not been acknowledged within TIMEOUT_CYCLES bus cycles (raises exc_bus).
// Without the macro the controller waits indefinitely and exc_bus is tied low.
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    // MEM-stage request
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // pipeline control and load result
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] rd_addr,
    output logic [2:0]  rd_op,
    // exceptions
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    // data bus
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        is_byte;
    logic        is_half;
    logic        aligned;
    logic        accept;
    logic        timeout_hit;
    logic        bus_err_q;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] addr_q;
    logic [2:0]  op_q;

    // A zero timeout would make the counter compare meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dmem_access_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    // Decode the access size and check natural alignment of the request.
    always_comb begin
        is_byte = (req_op == 3'b001) || (req_op == 3'b010);
        is_half = (req_op == 3'b011) || (req_op == 3'b100);
        if (is_byte) begin
            aligned = 1'b1;
        end else if (is_half) begin
            aligned = ~req_addr[0];
        end else begin
            aligned = (req_addr[1:0] == 2'b00);
        end
    end

    // Derive byte enables and replicate store data onto every lane it may use.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        be_next    = 4'b1111;
        wdata_next = req_wdata;
        if (req_we) begin
            if (is_byte) begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end else if (is_half) begin
                be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{req_wdata[15:0]}};
            end
        end
    end

    assign accept = (state == ST_IDLE) && req_valid && aligned;

    // State register; async reset drops bus_req without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking for all clocked state so reads see pre-edge values.
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one bus transaction per accepted request.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_BUS;
            ST_BUS:  if (bus_ack || timeout_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode: stall, result strobe, exceptions and bus request.
    always_comb begin
        stall    = accept || (state == ST_BUS);
        bus_req  = (state == ST_BUS);
        rd_valid = (state == ST_DONE) && !bus_we && !bus_err_q;
        exc_adel = (state == ST_IDLE) && req_valid && !aligned && !req_we;
        exc_ades = (state == ST_IDLE) && req_valid && !aligned &&  req_we;
        exc_bus  = (state == ST_DONE) && bus_err_q;
    end

    // Latch the bus transaction on acceptance; it stays stable through BUS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0000_0000;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0000_0000;
            addr_q    <= 32'h0000_0000;
            op_q      <= 3'b000;
        end else if (accept) begin
            bus_we    <= req_we;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_be    <= be_next;
            bus_wdata <= wdata_next;
            addr_q    <= req_addr;
            op_q      <= req_op;
        end
    end

    // Capture the read word with its address and size when the bus acks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= 32'h0000_0000;
            rd_addr <= 32'h0000_0000;
            rd_op   <= 3'b000;
        end else if ((state == ST_BUS) && bus_ack) begin
            rd_data <= bus_rdata;
            rd_addr <= addr_q;
            rd_op   <= op_q;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] bus_cnt;

    // The last permitted BUS cycle without an ack aborts; an ack in it wins.
    assign timeout_hit = (state == ST_BUS) && !bus_ack &&
                         (bus_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count unacknowledged BUS cycles and remember whether we timed out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_cnt   <= '0;
            bus_err_q <= 1'b0;
        end else if (accept) begin
            bus_cnt   <= '0;
            bus_err_q <= 1'b0;
        end else if ((state == ST_BUS) && !bus_ack) begin
            bus_cnt <= bus_cnt + 1'b1;
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err_q   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Randomized load/store traffic against a transaction-level expectation model.
// The driver schedules what each cycle of an access must look like; a single
// negedge process compares every DUT output against that schedule and keeps
// observation counters that the directed cases pin to literal values.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [31:0] rd_addr;
    logic [2:0]  rd_op;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_addr   (rd_addr),
        .rd_op     (rd_op),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .exc_bus   (exc_bus),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- expectation model ----------------
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_rd_valid, exp_adel, exp_ades, exp_bus_err;
    logic        exp_bus_req, exp_bus_we;
    logic [31:0] exp_bus_addr, exp_wdata, exp_rd_data, exp_rd_addr;
    logic [3:0]  exp_be;
    logic [2:0]  exp_rd_op;

    function automatic int size_bytes(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 1;
        if (op == 3'd3 || op == 3'd4) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] op, input logic [31:0] addr);
        int sz = size_bytes(op);
        if (!we || sz == 4) return 4'hF;
        if (sz == 2) return (addr % 4 >= 2) ? 4'b1100 : 4'b0011;
        return 4'(1 << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
        int sz = size_bytes(op);
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic exp_idle();
        exp_stall    = 1'b0;
        exp_rd_valid = 1'b0;
        exp_adel     = 1'b0;
        exp_ades     = 1'b0;
        exp_bus_err  = 1'b0;
        exp_bus_req  = 1'b0;
    endtask

    // ---------------- observation counters ----------------
    int          stall_cnt, rdv_cnt, busreq_cnt, adel_cnt, ades_cnt, buserr_cnt;
    logic        last_bwe;
    logic [31:0] last_baddr, last_wdata, last_rd_data, last_rd_addr;
    logic [3:0]  last_be;
    logic [2:0]  last_rd_op;

    task automatic clear_obs();
        stall_cnt = 0; rdv_cnt = 0; busreq_cnt = 0;
        adel_cnt = 0; ades_cnt = 0; buserr_cnt = 0;
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",    stall,    exp_stall);
            check("rd_valid", rd_valid, exp_rd_valid);
            check("exc_adel", exc_adel, exp_adel);
            check("exc_ades", exc_ades, exp_ades);
            check("exc_bus",  exc_bus,  exp_bus_err);
            check("bus_req",  bus_req,  exp_bus_req);
            if (exp_bus_req) begin
                check("bus_we",   bus_we,   exp_bus_we);
                check("bus_addr", bus_addr, exp_bus_addr);
                check("bus_be",   bus_be,   exp_be);
                if (exp_bus_we) check("bus_wdata", bus_wdata, exp_wdata);
            end
            if (exp_rd_valid) begin
                check("rd_data", rd_data, exp_rd_data);
                check("rd_addr", rd_addr, exp_rd_addr);
                check("rd_op",   rd_op,   exp_rd_op);
            end
            if (stall)    stall_cnt++;
            if (exc_adel) adel_cnt++;
            if (exc_ades) ades_cnt++;
            if (exc_bus)  buserr_cnt++;
            if (bus_req) begin
                busreq_cnt++;
                last_bwe   = bus_we;
                last_baddr = bus_addr;
                last_be    = bus_be;
                last_wdata = bus_wdata;
            end
            if (rd_valid) begin
                rdv_cnt++;
                last_rd_data = rd_data;
                last_rd_addr = rd_addr;
                last_rd_op   = rd_op;
            end
        end
    end

    // One access; entered and left just after a rising edge with the DUT idle.
    // lat = number of BUS cycles before the one that carries bus_ack.
    task automatic access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
        int  n_bus;
        bit  to;
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        bus_ack   = 1'($urandom_range(0, 1));   // ignored outside BUS
        bus_rdata = $urandom;
        exp_idle();
        if (addr % size_bytes(op) != 0) begin
            exp_adel = !we;
            exp_ades = we;
            @(posedge clk); #1;
            req_valid = 1'b0;
            bus_ack   = 1'b0;
            exp_idle();
            return;
        end
        exp_stall = 1'b1;
        n_bus = lat + 1;
        to    = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        if (n_bus > TO) begin
            n_bus = TO;
            to    = 1'b1;
        end
`endif
        @(posedge clk); #1;
        exp_bus_req  = 1'b1;
        exp_bus_we   = we;
        exp_bus_addr = addr & ~32'h3;
        exp_be       = model_be(we, op, addr);
        exp_wdata    = model_wdata(op, wdata);
        for (int k = 1; k <= n_bus; k++) begin
            bus_ack   = (!to && k == n_bus);
            bus_rdata = bus_ack ? rdata : $urandom;
            if (k != n_bus) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        bus_ack      = 1'($urandom_range(0, 1));  // ignored in DONE
        bus_rdata    = $urandom;
        exp_stall    = 1'b0;
        exp_bus_req  = 1'b0;
        exp_rd_valid = !we && !to;
        exp_bus_err  = to;
        exp_rd_data  = rdata;
        exp_rd_addr  = addr;
        exp_rd_op    = op;
        @(posedge clk); #1;
        req_valid = 1'b0;
        bus_ack   = 1'b0;
        exp_idle();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        exp_idle();
        #1;
        check("reset_stall",   stall,   1'b0);
        check("reset_bus_req", bus_req, 1'b0);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_rd_addr", rd_addr, 32'h0);
        check("reset_bus_be",  bus_be,  4'h0);
        idle_cycles(2);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        idle_cycles(1);

        // lw, immediate ack
        clear_obs();
        access(1'b0, 3'd0, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF);
        check("lw_stall_cycles", stall_cnt,    2);
        check("lw_rd_valid_cnt", rdv_cnt,      1);
        check("lw_rd_data",      last_rd_data, 32'hDEAD_BEEF);
        check("lw_rd_addr",      last_rd_addr, 32'h0000_0104);
        check("lw_rd_op",        last_rd_op,   3'b000);
        check("lw_bus_addr",     last_baddr,   32'h0000_0104);
        check("lw_bus_be",       last_be,      4'b1111);

        // sb lane 3
        clear_obs();
        access(1'b1, 3'd1, 32'h0000_0203, 32'h0000_00A5, 0, 32'h1111_2222);
        check("sb_bus_we",    last_bwe,   1'b1);
        check("sb_bus_addr",  last_baddr, 32'h0000_0200);
        check("sb_bus_be",    last_be,    4'b1000);
        check("sb_bus_wdata", last_wdata, 32'hA5A5_A5A5);
        check("sb_no_rdv",    rdv_cnt,    0);

        // sh upper half, ack delayed 3 cycles
        clear_obs();
        access(1'b1, 3'd3, 32'h0000_0012, 32'h0000_1234, 3, 32'h0);
        check("sh_bus_be",       last_be,    4'b1100);
        check("sh_bus_wdata",    last_wdata, 32'h1234_1234);
        check("sh_stall_cycles", stall_cnt,  5);
        check("sh_bus_cycles",   busreq_cnt, 4);

        // misaligned accesses
        clear_obs();
        access(1'b0, 3'd0, 32'h0000_0102, 32'h0, 0, 32'h0);
        access(1'b0, 3'd3, 32'h0000_0101, 32'h0, 0, 32'h0);
        access(1'b1, 3'd0, 32'h0000_0001, 32'h0, 0, 32'h0);
        check("mis_adel_cnt", adel_cnt,   2);
        check("mis_ades_cnt", ades_cnt,   1);
        check("mis_no_bus",   busreq_cnt, 0);
        check("mis_no_stall", stall_cnt,  0);

        // back-to-back: second request the cycle after DONE
        clear_obs();
        access(1'b0, 3'd4, 32'h0000_0306, 32'h0, 1, 32'hCAFE_F00D);
        access(1'b0, 3'd2, 32'h0000_0401, 32'h0, 0, 32'h0BAD_CAFE);
        check("b2b_rdv_cnt", rdv_cnt,      2);
        check("b2b_rd_data", last_rd_data, 32'h0BAD_CAFE);

        // reset while in BUS
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0;
        req_addr  = 32'h0000_0040; req_wdata = 32'h0;
        exp_idle();
        exp_stall = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b0;
        #2;
        check("pre_reset_bus_req", bus_req, 1'b1);
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("rst_bus_req",  bus_req,  1'b0);
        check("rst_stall",    stall,    1'b0);
        check("rst_rd_data",  rd_data,  32'h0);
        check("rst_rd_addr",  rd_addr,  32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be",   bus_be,   4'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_idle();
        chk_en = 1'b1;
        clear_obs();
        access(1'b0, 3'd0, 32'h0000_0080, 32'h0, 2, 32'h1357_9BDF);
        check("post_rst_rd_data", last_rd_data, 32'h1357_9BDF);

`ifdef DMEM_TIMEOUT_EN
        clear_obs();
        access(1'b0, 3'd0, 32'h0000_0500, 32'h0, 20, 32'h0);
        check("to_exc_bus_cnt", buserr_cnt, 1);
        check("to_bus_cycles",  busreq_cnt, TO);
        check("to_no_rdv",      rdv_cnt,    0);
        clear_obs();
        access(1'b0, 3'd0, 32'h0000_0504, 32'h0, TO - 1, 32'h2468_ACE0);
        check("ack4_exc_bus_cnt", buserr_cnt,   0);
        check("ack4_rd_data",     last_rd_data, 32'h2468_ACE0);
`endif

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;  // bias toward aligned
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), a, $urandom,
                   $urandom_range(0, 6), $urandom);
            idle_cycles($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller in the MEM stage of the MIPS pipeline, directly upstream of the load extension unit. It turns a load/store request into a word-aligned bus transaction with byte enables and replicated store data, and stalls the pipeline until the bus acknowledges. It then hands the raw read word, its byte address and its size code downstream for extraction and extension. Misaligned accesses are trapped before any bus activity.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, bus cycles to wait for `bus_ack` before declaring a bus error (only used with the timeout feature).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage holds a load or store.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  size code:
  - 000 word.
  - 001 byte signed.
  - 010 byte unsigned.
  - 011 half signed.
  - 100 half unsigned.
  - Stores treat 001/010 as sb and 011/100 as sh.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  freeze pipeline stages up to and including MEM.
- rd_valid  out  1  one-cycle strobe: `rd_data`, `rd_addr` and `rd_op` are valid for a load.
- rd_data  out  32  raw word from the bus.
- rd_addr  out  32  latched byte address.
- rd_op  out  3  latched size code.
- exc_adel  out  1  misaligned load.
- exc_ades  out  1  misaligned store.
- exc_bus  out  1  bus timeout.
- bus_req  out  1  transaction request.
- bus_we  out  1  write.
- bus_addr  out  32  word address, with [1:0] = 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete; `bus_rdata` is valid.
- bus_rdata  in  32  read word.

## Operation
- Alignment check, evaluated combinationally in IDLE:
  - Word access requires addr[1:0] = 00.
  - Half access requires addr[0] = 0.
  - Byte access is always aligned.
- Misaligned request in IDLE:
  - `exc_adel` (load) or `exc_ades` (store) is high in that same cycle.
  - No bus access and no `stall`; the state stays IDLE.
- Byte enables and store data:
  - sw: be = 1111, wdata as given.
  - sh: be = 0011 if addr[1] = 0, else 1100; wdata = {2{wdata[15:0]}}.
  - sb: be = 0001 shifted left by addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Loads: be = 1111, bus_we = 0.
- States:
  - IDLE: on an aligned `req_valid`, latch address, op, we, be and wdata, then go to BUS.
  - BUS: `bus_req` = 1 with all bus outputs held stable. On `bus_ack`, capture `bus_rdata` and go to DONE.
  - DONE: `rd_valid` = 1 for loads only. Request inputs are ignored (the pipeline still holds the same instruction). Return to IDLE.
- `stall` = (IDLE && req_valid && aligned) || BUS. `stall` is low in DONE, so the instruction retires at the end of DONE.
- `bus_ack` outside BUS is ignored.
- `rd_data`, `rd_addr` and `rd_op` hold their last values until the next capture.

## Timing
- Reset (asynchronous): state = IDLE, all outputs 0 (`rd_data` and `rd_addr` cleared to 0x00000000).
- Asserting reset mid-transaction drops `bus_req` immediately, without waiting for a clock edge.
- Minimum access is 3 cycles when `bus_ack` arrives in the first BUS cycle:
  - Cycle 0: IDLE, stall.
  - Cycle 1: BUS, stall.
  - Cycle 2: DONE, no stall.
- Each extra cycle of `bus_ack` latency adds one BUS cycle.
- Exception outputs are combinational in IDLE and are otherwise 0, except `exc_bus`.
- Back-to-back accesses: a new request is accepted in the cycle after DONE.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entry to BUS and increments each BUS cycle without `bus_ack`.
  - When the count reaches TIMEOUT_CYCLES, drop `bus_req`, go to DONE with `exc_bus` = 1 and `rd_valid` = 0.
  - If `bus_ack` arrives in the same cycle as the timeout, the ack wins and no error is raised.
- DMEM_TIMEOUT_EN undefined:
  - BUS waits indefinitely for `bus_ack`.
  - `exc_bus` is tied to 0 and no counter exists.

## Test plan
- **lw, immediate ack:** lw addr 0x00000104, `bus_ack` in first BUS cycle with rdata 0xDEADBEEF → bus_addr 0x104, be 1111, stall high 2 cycles, `rd_valid` in cycle 2 with rd_data 0xDEADBEEF, rd_addr 0x104, rd_op 000.
- **sb lane 3:** sb addr 0x00000203, wdata 0x000000A5 → bus_we 1, bus_addr 0x200, be 1000, bus_wdata 0xA5A5A5A5, no `rd_valid`.
- **sh upper half, delayed ack:** sh addr 0x00000012, wdata 0x00001234, ack delayed 3 cycles → be 1100, bus_wdata 0x12341234, bus outputs stable throughout, stall high 5 cycles total.
- **Misalignment:**
  - lw addr 0x00000102 → `exc_adel` = 1 same cycle, `bus_req` never rises, stall 0.
  - lh addr 0x00000101 → `exc_adel` = 1.
  - sw addr 0x00000001 → `exc_ades` = 1.
- **Reset mid-access:** reset_n low while in BUS → `bus_req` 0 at once, state IDLE, all outputs 0; a request after release proceeds normally.
- **Timeout (DMEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4):**
  - No ack → `exc_bus` pulse after 4 BUS cycles, `rd_valid` 0.
  - Ack exactly on the 4th BUS cycle → normal completion, `exc_bus` 0.
